// File: rtl/secuenciador_sumas.sv
// secuenciador_sumas: self-checking stimulus sequencer for the selective
// adder/accumulator. An LFSR produces the operands, an internal model of the
// accumulator predicts the DUT result, and mismatches are counted.
module secuenciador_sumas #(
  parameter int N_OPS_W    = 8,
  parameter int ERR_W      = 8,
  parameter int RST_CYCLES = 4,
  parameter int CHECK_LAT  = 1
) (
  input  logic               clock,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [N_OPS_W-1:0] i_n_ops,
  input  logic [7:0]         i_seed,
  input  logic [5:0]         i_dut_data,
  input  logic               i_dut_overflow,
  output logic [2:0]         o_data1,
  output logic [2:0]         o_data2,
  output logic [1:0]         o_sel,
  output logic               o_dut_rst_n,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [ERR_W-1:0]   o_err_count
);

  localparam int CNT_MAX = (RST_CYCLES > CHECK_LAT) ? RST_CYCLES : CHECK_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(CHECK_LAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_DUT = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state;
  logic [N_OPS_W-1:0] n_ops;
  logic [N_OPS_W-1:0] ops_left;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         lfsr;

  // Accumulator model (stage 0) and the alignment pipeline behind it
  logic [5:0] acc;
  logic       ovf;
  logic       mdl_vld;
  logic [5:0] pipe_acc [CHECK_LAT];
  logic       pipe_ovf [CHECK_LAT];
  logic       pipe_vld [CHECK_LAT];

  logic             start_ok;
  logic             op_fire;
  logic [5:0]       acc_base;
  logic             ovf_base;
  logic [6:0]       sum_full;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // 4-bit selective adder result, unsigned, subtraction wraps mod 16
  function automatic logic [3:0] suma(input logic [2:0] a, input logic [2:0] b,
                                      input logic [1:0] s);
    logic [3:0] r;
    case (s)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} - {1'b0, b};
      2'b10:   r = {1'b0, a};
      default: r = {1'b0, b};
    endcase
    return r;
  endfunction

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Decode of this cycle's operation, model update and result comparison
  always_comb begin
    start_ok = ((state == IDLE) || (state == DONE)) && i_start;
    op_fire  = 1'b0;
    case (state)
      RST_DUT: op_fire = (cnt == RST_LAST) && (n_ops != {N_OPS_W{1'b0}});
      RUN:     op_fire = (ops_left != {N_OPS_W{1'b0}});
      default: op_fire = 1'b0;
    endcase
    // The DUT is in reset during RST_DUT, so the first op starts from zero
    if (state == RST_DUT) begin
      acc_base = 6'd0;
      ovf_base = 1'b0;
    end else begin
      acc_base = acc;
      ovf_base = ovf;
    end
    sum_full = {1'b0, acc_base} + {3'b000, suma(lfsr[2:0], lfsr[5:3], lfsr[7:6])};
    mismatch = pipe_vld[CHECK_LAT-1] && ((state == RUN) || (state == DRAIN)) &&
               ((i_dut_data != pipe_acc[CHECK_LAT-1]) ||
                (i_dut_overflow != pipe_ovf[CHECK_LAT-1]));
    if (mismatch && (o_err_count != ERR_MAX)) begin
      err_next = o_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_next = o_err_count;
    end
  end

  // Run-control FSM with all outputs registered
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      n_ops       <= {N_OPS_W{1'b0}};
      ops_left    <= {N_OPS_W{1'b0}};
      cnt         <= {CNT_W{1'b0}};
      lfsr        <= 8'h01;
      o_data1     <= 3'd0;
      o_data2     <= 3'd0;
      o_sel       <= 2'b00;
      o_dut_rst_n <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_err_count <= {ERR_W{1'b0}};
    end else if (start_ok) begin
      state       <= RST_DUT;
      n_ops       <= i_n_ops;
      lfsr        <= (i_seed == 8'h00) ? 8'h01 : i_seed;
      cnt         <= {CNT_W{1'b0}};
      o_data1     <= 3'd0;
      o_data2     <= 3'd0;
      o_sel       <= 2'b00;
      o_dut_rst_n <= 1'b0;
      o_busy      <= 1'b1;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_err_count <= {ERR_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          o_dut_rst_n <= 1'b1;
        end
        RST_DUT: begin
          cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt == RST_LAST) begin
            o_dut_rst_n <= 1'b1;
            if (n_ops == {N_OPS_W{1'b0}}) begin
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              o_pass <= 1'b1;
            end else begin
              state    <= RUN;
              o_data1  <= lfsr[2:0];
              o_data2  <= lfsr[5:3];
              o_sel    <= lfsr[7:6];
              lfsr     <= lfsr_step(lfsr);
              ops_left <= n_ops - {{(N_OPS_W-1){1'b0}}, 1'b1};
            end
          end
        end
        RUN: begin
          o_err_count <= err_next;
          if (ops_left != {N_OPS_W{1'b0}}) begin
            o_data1  <= lfsr[2:0];
            o_data2  <= lfsr[5:3];
            o_sel    <= lfsr[7:6];
            lfsr     <= lfsr_step(lfsr);
            ops_left <= ops_left - {{(N_OPS_W-1){1'b0}}, 1'b1};
          end else begin
            // Zero operands while the last results come back
            state   <= DRAIN;
            o_data1 <= 3'd0;
            o_data2 <= 3'd0;
            o_sel   <= 2'b00;
            cnt     <= {CNT_W{1'b0}};
          end
        end
        DRAIN: begin
          o_err_count <= err_next;
          cnt         <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt == LAT_LAST) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_pass <= (err_next == {ERR_W{1'b0}});
          end
        end
        DONE: begin
          o_done <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
          o_pass <= 1'b0;
        end
      endcase
    end
  end

  // Accumulator model and the pipeline aligning it with the DUT latency
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      acc     <= 6'd0;
      ovf     <= 1'b0;
      mdl_vld <= 1'b0;
      for (int i = 0; i < CHECK_LAT; i++) begin
        pipe_acc[i] <= 6'd0;
        pipe_ovf[i] <= 1'b0;
        pipe_vld[i] <= 1'b0;
      end
    end else begin
      mdl_vld <= op_fire;
      if (op_fire) begin
        acc <= sum_full[5:0];
        ovf <= ovf_base | sum_full[6];
      end else if (state == RST_DUT) begin
        acc <= 6'd0;
        ovf <= 1'b0;
      end
      if (state == RST_DUT) begin
        for (int i = 0; i < CHECK_LAT; i++) begin
          pipe_vld[i] <= 1'b0;
        end
      end else begin
        pipe_acc[0] <= acc;
        pipe_ovf[0] <= ovf;
        pipe_vld[0] <= mdl_vld;
        for (int i = 1; i < CHECK_LAT; i++) begin
          pipe_acc[i] <= pipe_acc[i-1];
          pipe_ovf[i] <= pipe_ovf[i-1];
          pipe_vld[i] <= pipe_vld[i-1];
        end
      end
    end
  end

endmodule

// File: doc/secuenciador_sumas.md
# secuenciador_sumas

Self-checking stimulus sequencer for the selective-adder/accumulator datapath: it drives the operand side (`data1`, `data2`, `sel`, active-low DUT reset) and reads back the accumulated result and overflow flag. It replaces the interactive probe in hardware runs.
- An internal LFSR generates a programmable number of operations.
- A reference model of the accumulator checks every result.
- It reports pass/fail and an error count.

## Interface
- `N_OPS_W`, 8: width of the operation-count input.
- `ERR_W`, 8: width of the error counter; the counter saturates.
- `RST_CYCLES`, 4: number of cycles `o_dut_rst_n` is held low at run start; must be ≥1.
- `CHECK_LAT`, 1: cycles from operand presentation to the DUT output reflecting that operand; must be ≥1.

Ports:
- `clock`  in  1  system clock, rising edge.
- `i_rst`  in  1  asynchronous reset, active-high.
- `i_start`  in  1  start a run; sampled in IDLE or DONE only.
- `i_n_ops`  in  N_OPS_W  operations per run; latched at start.
- `i_seed`  in  8  LFSR seed, latched at start; 8'h00 is replaced by 8'h01.
- `i_dut_data`  in  6  accumulated value from the DUT.
- `i_dut_overflow`  in  1  overflow flag from the DUT.
- `o_data1`  out  3  operand 1 to the DUT.
- `o_data2`  out  3  operand 2 to the DUT.
- `o_sel`  out  2  operation select to the DUT.
- `o_dut_rst_n`  out  1  active-low reset to the DUT.
- `o_busy`  out  1  high in RST_DUT, RUN and DRAIN.
- `o_done`  out  1  high in DONE.
- `o_pass`  out  1  high in DONE when the error count is zero.
- `o_err_count`  out  ERR_W  number of mismatches; saturating.

## Operation
States and transitions:
- IDLE → RST_DUT on `i_start`.
- RST_DUT: `o_dut_rst_n`=0 for RST_CYCLES cycles. The model accumulator and sticky overflow are cleared. Then RUN, or DONE when `n_ops`=0.
- RUN: one operation per cycle. Operands come from the current LFSR state: `o_data1`=lfsr[2:0], `o_data2`=lfsr[5:3], `o_sel`=lfsr[7:6]. The LFSR then advances (Fibonacci, x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0). After `n_ops` operations, go to DRAIN.
- DRAIN: CHECK_LAT cycles, operands forced to 0 and `o_sel`=00, so the DUT adds 0. Then DONE.
- DONE: holds until `i_start`, which restarts the run at RST_DUT.

Reference model:
- `o_sel` 00 → suma = d1+d2; 01 → (d1−d2) mod 16; 10 → d1; 11 → d2. The result is 4 bits, unsigned.
- Accumulator update: `acc` = (`acc` + suma) mod 64.
- Overflow: set on carry out of bit 5 and sticky until DUT reset.

Checking:
- Expected `acc` and overflow pass through a CHECK_LAT-deep pipeline.
- Each RUN/DRAIN cycle that carries a valid op is checked against `i_dut_data` and `i_dut_overflow`.
- Any difference increments `o_err_count`, saturating at 2^ERR_W−1.

Control rules:
- `i_start` is ignored while `o_busy`.
- `i_start` in DONE clears `o_err_count`, `o_done` and `o_pass`.
- `i_n_ops`, `i_seed`, `i_dut_*` changes mid-run: count and seed are latched, so changes have no effect until the next start.

## Timing
- Reset values: operands 0, `o_sel` 00, `o_dut_rst_n`=0 while `i_rst` is high, then 1 in IDLE. `o_busy`/`o_done`/`o_pass` 0, `o_err_count` 0, state IDLE.
- `i_rst` asserted mid-run aborts immediately (asynchronous) and returns to IDLE with no DONE.
- `i_start` is high at edge e0. RST_DUT begins at e0, with `o_dut_rst_n` low from e0 to e0+RST_CYCLES. The first operands are registered at e0+RST_CYCLES.
- Operand k is presented after edge t_k and checked at edge t_k+CHECK_LAT.
- `o_done` rises at e0 + RST_CYCLES + n_ops + CHECK_LAT.
- `n_ops`=0: DONE at e0+RST_CYCLES, with `o_pass`=1.
- All outputs are registered.

## Test plan
- Correct behavioral DUT, seed 8'h01, `n_ops`=1 → operands d1=1, d2=0, sel=00. Expect `i_dut_data`=1, `o_done` at cycle 4+1+1=6 after start, `o_pass`=1, `o_err_count`=0.
- Correct DUT, `n_ops`=200 → overflow sets and stays high once `acc` wraps past 63. Expect `o_pass`=1 and `o_err_count`=0.
- DUT stub with bit 0 of data stuck at 0, `n_ops`=10 → `o_pass`=0, `o_err_count` equals the model's count of cycles with expected bit 0 = 1.
- ERR_W=2, always-wrong DUT, `n_ops`=10 → `o_err_count` saturates at 3.
- `i_rst` pulsed mid-RUN → next cycle state is IDLE, outputs at reset values, `o_done`=0. A new `i_start` with the same seed reproduces an identical operand sequence.
- `i_start` held high during RUN → no restart. `n_ops`=0 → DONE at e0+4 with `o_pass`=1.
